// File: rtl/noc_arb_pkg.sv
// Shared constants for the NoC arbitration blocks: flit id codes and default widths.
package noc_arb_pkg;

  localparam int LEN_W_DEF = 12;
  localparam int FID_W_DEF = 3;

  localparam logic [2:0] FID_HEADER = 3'b001;
  localparam logic [2:0] FID_TAIL   = 3'b010;

endpackage

// File: rtl/port_timer.sv
// Per-port grant timer: header-loaded limit, saturating hold counter and expiry compare.
module port_timer
  import noc_arb_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int FID_W = FID_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             granted,
  input  logic [FID_W-1:0] flit_id,
  input  logic [LEN_W-1:0] length,
  output logic             expired
);

  logic [LEN_W-1:0] limit;
  logic [LEN_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      limit <= '0;
      count <= '0;
    end else begin
      if (flit_id == FID_W'(FID_HEADER)) limit <= length;
      if (!granted || !req)              count <= '0;
      else if (count != '1)              count <= count + LEN_W'(1);
    end
  end

  // A zero limit means the holder may keep the grant indefinitely.
  assign expired = granted && req && (limit != '0) && (count == limit - LEN_W'(1));

endmodule

// File: rtl/rr_timeout_arbiter.sv
// Round-robin arbiter whose holder is pre-empted after a per-port, header-programmed
// number of consecutive grant cycles.
//   state    | meaning
//   IDLE     | grant == 0, next grant goes to the lowest-index requester
//   GRANT_i  | grant == one-hot(i), port i holds until req drops or it expires
module rr_timeout_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NUM_PORTS = 5,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int FID_W     = FID_W_DEF,
  localparam int IDX_W    = $clog2(NUM_PORTS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS-1:0]       req,
  input  logic [NUM_PORTS*FID_W-1:0] flit_id,
  input  logic [NUM_PORTS*LEN_W-1:0] length,
  output logic [NUM_PORTS-1:0]       grant,
  output logic                       grant_valid,
  output logic [IDX_W-1:0]           grant_idx,
  output logic [NUM_PORTS-1:0]       timeout
);

  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [NUM_PORTS-1:0] timeout_q;
  logic [NUM_PORTS-1:0] expired;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 valid_q, valid_d;
  logic                 found;
  int                   j;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_timer
    port_timer #(.LEN_W(LEN_W), .FID_W(FID_W)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .req     (req[i]),
      .granted (grant_q[i]),
      .flit_id (flit_id[i*FID_W +: FID_W]),
      .length  (length[i*LEN_W +: LEN_W]),
      .expired (expired[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q   <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= '0;
    end else begin
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= expired;
    end
  end

  // Round-robin search starts just past the holder and never revisits it.
  always_comb begin
    grant_d = '0;
    idx_d   = '0;
    found   = 1'b0;
    j       = 0;
    if (!valid_q) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!found && req[i]) begin
          found      = 1'b1;
          grant_d[i] = 1'b1;
          idx_d      = IDX_W'(i);
        end
      end
    end else if (req[idx_q] && !expired[idx_q]) begin
      found   = 1'b1;
      grant_d = grant_q;
      idx_d   = idx_q;
    end else begin
      for (int k = 1; k < NUM_PORTS; k++) begin
        j = int'(idx_q) + k;
        if (j >= NUM_PORTS) j = j - NUM_PORTS;
        if (!found && req[j]) begin
          found      = 1'b1;
          grant_d[j] = 1'b1;
          idx_d      = IDX_W'(j);
        end
      end
    end
    valid_d = found;
  end

  always_comb begin
    grant       = grant_q;
    grant_valid = valid_q;
    grant_idx   = idx_q;
    timeout     = timeout_q;
  end

endmodule

// File: tb/tb_rr_timeout_arbiter.sv
// Directed bench for rr_timeout_arbiter with hand-computed grant/timeout sequences.
module tb_rr_timeout_arbiter;

  localparam int NP    = 5;
  localparam int LEN_W = 12;
  localparam int FID_W = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NP-1:0]          req;
  logic [NP*FID_W-1:0]    flit_id;
  logic [NP*LEN_W-1:0]    length;
  logic [NP-1:0]          grant;
  logic                   grant_valid;
  logic [$clog2(NP)-1:0]  grant_idx;
  logic [NP-1:0]          timeout;

  int checks   = 0;
  int failures = 0;
  int drops;

  rr_timeout_arbiter #(.NUM_PORTS(NP), .LEN_W(LEN_W), .FID_W(FID_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .flit_id     (flit_id),
    .length      (length),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_hdr(input int p, input int len);
    flit_id[p*FID_W +: FID_W] = 3'b001;
    length[p*LEN_W +: LEN_W]  = LEN_W'(len);
  endtask

  task automatic check_grant(input string tag, input logic [NP-1:0] g, input int idx, input logic [NP-1:0] t);
    check({tag, "_grant"}, 32'(grant), 32'(g));
    check({tag, "_valid"}, 32'(grant_valid), 32'(g != '0));
    check({tag, "_idx"},   32'(grant_idx), 32'(idx));
    check({tag, "_tmo"},   32'(timeout), 32'(t));
  endtask

  initial begin
    rst = 1'b1; req = '0; flit_id = '0; length = '0;
    #3;
    check_grant("rst_async", 5'b00000, 0, 5'b00000);
    step(); step();
    rst = 1'b0;

    // lowest requester from idle
    req = 5'b10110; step();
    check_grant("idle_pick", 5'b00010, 1, 5'b00000);

    // holder drops req: no timeout pulse
    req = 5'b00000; step();
    check_grant("req_drop", 5'b00000, 0, 5'b00000);

    // port 1 limit 4, then hand over to port 2
    set_hdr(1, 4); req = 5'b00010; step();
    flit_id = '0; req = 5'b10110;
    for (int c = 0; c < 4; c++) begin
      check_grant("lim4_hold", 5'b00010, 1, 5'b00000);
      step();
    end
    check_grant("lim4_next", 5'b00100, 2, 5'b00010);
    step();
    check_grant("lim4_after", 5'b00100, 2, 5'b00000);

    // round-robin skips idle port 3, then wraps past 4 to 0
    req = 5'b10010; step();
    check_grant("rr_skip", 5'b10000, 4, 5'b00000);
    req = 5'b10011; step();
    check_grant("rr_hold", 5'b10000, 4, 5'b00000);
    req = 5'b00011; step();
    check_grant("rr_wrap", 5'b00001, 0, 5'b00000);

    // unlimited holder (limit 0) past counter saturation
    req = 5'b00000; step();
    req = 5'b01000; step();
    check_grant("unlim_start", 5'b01000, 3, 5'b00000);
    drops = 0;
    repeat (5000) begin
      step();
      if (grant !== 5'b01000 || timeout !== 5'b00000) drops++;
    end
    check("unlim_drops", 32'(drops), 32'd0);

    // sole requester with limit 2: 1,1,0 pattern
    req = 5'b00000; step();
    set_hdr(4, 2); req = 5'b10000; step();
    flit_id = '0;
    for (int c = 0; c < 9; c++) begin
      if (c % 3 == 2) check_grant("lim2_gap", 5'b00000, 0, 5'b10000);
      else            check_grant("lim2_on",  5'b10000, 4, 5'b00000);
      step();
    end

    // limit raised from 3 to 7 mid-grant
    req = 5'b00000; step();
    set_hdr(0, 3); req = 5'b00001; step();
    check_grant("relim_c0", 5'b00001, 0, 5'b00000);
    set_hdr(0, 7); step();
    flit_id = '0;
    for (int c = 1; c < 7; c++) begin
      check_grant("relim_hold", 5'b00001, 0, 5'b00000);
      step();
    end
    check_grant("relim_end", 5'b00000, 0, 5'b00001);

    // reset between edges mid-grant
    req = 5'b01000; step();
    check_grant("pre_rst", 5'b01000, 3, 5'b00000);
    req = 5'b01010; step();
    check_grant("pre_rst_hold", 5'b01000, 3, 5'b00000);
    #2 rst = 1'b1;
    #1;
    check_grant("mid_rst", 5'b00000, 0, 5'b00000);
    step();
    rst = 1'b0; step();
    check_grant("post_rst", 5'b00010, 1, 5'b00000);

    // reset cleared port 4's limit of 2
    req = 5'b00000; step();
    req = 5'b10000; step();
    for (int c = 0; c < 4; c++) begin
      check_grant("rst_lim_clr", 5'b10000, 4, 5'b00000);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
